// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write-port arbiter: pipeline writeback vs buffered MDU results.
// Optional WB_ARB_PERF_EN adds saturating forced-stall and MDU-drain counters.
module wb_port_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int DW           = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_reg_we_i,
  input  logic [4:0]    wb_wR_i,
  input  logic [DW-1:0] wb_wD_i,
  input  logic          mdu_valid_i,
  input  logic [4:0]    mdu_wR_i,
  input  logic [DW-1:0] mdu_wD_i,
  output logic          mdu_ready_o,
  output logic          pipe_stall_o,
  output logic [31:0]   busy_mask_o,
  output logic          rf_we_o,
  output logic [4:0]    rf_wR_o,
  output logic [DW-1:0] rf_wD_o
`ifdef WB_ARB_PERF_EN
  ,
  output logic [15:0]   perf_stall_cnt_o,
  output logic [15:0]   perf_mdu_wr_cnt_o
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    q_wr [FIFO_DEPTH];
  logic [DW-1:0] q_wd [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, off;
  logic [CW-1:0] count;
  logic [3:0]    age;
  logic          head_valid, wb_live, enq, drain;

  always_comb begin
    head_valid   = (count != '0);
    mdu_ready_o  = (count < CW'(FIFO_DEPTH));
    pipe_stall_o = head_valid && (age >= 4'(STARVE_LIMIT));
    wb_live      = wb_reg_we_i && (wb_wR_i != 5'd0);
    // x0 results still complete the handshake but are never stored
    enq          = mdu_valid_i && mdu_ready_o && (mdu_wR_i != 5'd0);
    drain        = pipe_stall_o || (head_valid && !wb_live);
  end

  always_comb begin
    busy_mask_o = '0;
    off         = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      off = AW'(i) - rd_ptr;
      if ({1'b0, off} < count)
        busy_mask_o = busy_mask_o | (32'd1 << q_wr[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && enq) begin
      q_wr[wr_ptr] <= mdu_wR_i;
      q_wd[wr_ptr] <= mdu_wD_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      age     <= '0;
      rf_we_o <= 1'b0;
      rf_wR_o <= '0;
      rf_wD_o <= '0;
    end else begin
      if (enq)
        wr_ptr <= wr_ptr + 1'b1;
      if (drain)
        rd_ptr <= rd_ptr + 1'b1;
      case ({enq, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drain)
        age <= '0;
      else if (wb_live && head_valid && age != 4'hF)
        age <= age + 4'd1;
      rf_we_o <= drain || wb_live;
      if (drain) begin
        rf_wR_o <= q_wr[rd_ptr];
        rf_wD_o <= q_wd[rd_ptr];
      end else if (wb_live) begin
        rf_wR_o <= wb_wR_i;
        rf_wD_o <= wb_wD_i;
      end
    end
  end

`ifdef WB_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt_o  <= '0;
      perf_mdu_wr_cnt_o <= '0;
    end else begin
      if (pipe_stall_o && perf_stall_cnt_o != 16'hFFFF)
        perf_stall_cnt_o <= perf_stall_cnt_o + 16'd1;
      if (drain && perf_mdu_wr_cnt_o != 16'hFFFF)
        perf_mdu_wr_cnt_o <= perf_mdu_wr_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - self-checking bench for wb_port_arbiter with a queue-based reference model.
module tb_wb_port_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_reg_we_i;
  logic [4:0]  wb_wR_i;
  logic [31:0] wb_wD_i;
  logic        mdu_valid_i;
  logic [4:0]  mdu_wR_i;
  logic [31:0] mdu_wD_i;
  logic        mdu_ready_o;
  logic        pipe_stall_o;
  logic [31:0] busy_mask_o;
  logic        rf_we_o;
  logic [4:0]  rf_wR_o;
  logic [31:0] rf_wD_o;

  always #5 clk = ~clk;

  wb_port_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .wb_reg_we_i(wb_reg_we_i), .wb_wR_i(wb_wR_i), .wb_wD_i(wb_wD_i),
    .mdu_valid_i(mdu_valid_i), .mdu_wR_i(mdu_wR_i), .mdu_wD_i(mdu_wD_i),
    .mdu_ready_o(mdu_ready_o), .pipe_stall_o(pipe_stall_o), .busy_mask_o(busy_mask_o),
    .rf_we_o(rf_we_o), .rf_wR_o(rf_wR_o), .rf_wD_o(rf_wD_o)
  );

  int n_chk  = 0;
  int n_fail = 0;

  ent_t        mq[$];
  int          age = 0;
  logic        e_we = 1'b0;
  logic [4:0]  e_wr = '0;
  logic [31:0] e_wd = '0;
  bit          mvalid = 0;
  bit          last_stall = 0;
  bit          last_acc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_mask();
    logic [31:0] m = '0;
    foreach (mq[i]) m = m | (32'd1 << mq[i].r);
    return m;
  endfunction

  // Compare DUT against the model, advance the model by one clock, then step the clock.
  task automatic cycle();
    bit   hv, st, rdy, live, acc;
    ent_t h;
    if (mvalid) begin
      chk("rf_we", 32'(rf_we_o), 32'(e_we));
      if (e_we) begin
        chk("rf_wR", 32'(rf_wR_o), 32'(e_wr));
        chk("rf_wD", rf_wD_o, e_wd);
      end
      chk("mdu_ready", 32'(mdu_ready_o), 32'(mq.size() < DEPTH));
      chk("pipe_stall", 32'(pipe_stall_o), 32'(mq.size() != 0 && age >= LIMIT));
      chk("busy_mask", busy_mask_o, m_mask());
    end
    if (rst) begin
      mq.delete();
      age = 0; e_we = 0; e_wr = '0; e_wd = '0;
      mvalid = 1; last_stall = 0; last_acc = 0;
    end else begin
      hv   = mq.size() != 0;
      st   = hv && age >= LIMIT;
      rdy  = mq.size() < DEPTH;
      live = wb_reg_we_i && wb_wR_i != 5'd0;
      acc  = mdu_valid_i && rdy;
      if (st || (hv && !live)) begin
        h = mq.pop_front();
        e_we = 1; e_wr = h.r; e_wd = h.d; age = 0;
      end else if (live) begin
        e_we = 1; e_wr = wb_wR_i; e_wd = wb_wD_i;
        if (hv && age < 15) age++;
      end else begin
        e_we = 0;
      end
      if (acc && mdu_wR_i != 5'd0) begin
        h.r = mdu_wR_i; h.d = mdu_wD_i;
        mq.push_back(h);
      end
      last_stall = st;
      last_acc   = acc;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int stall_cnt, stall_k, drained, seq, acc_k;
    int ord[$];

    rst = 1; wb_reg_we_i = 0; wb_wR_i = '0; wb_wD_i = '0;
    mdu_valid_i = 0; mdu_wR_i = '0; mdu_wD_i = '0;
    cycle(); cycle();
    rst = 0;
    chk("reset rf_we", 32'(rf_we_o), 32'd0);
    chk("reset rf_wR", 32'(rf_wR_o), 32'd0);
    chk("reset rf_wD", rf_wD_o, 32'd0);
    chk("reset ready", 32'(mdu_ready_o), 32'd1);
    chk("reset stall", 32'(pipe_stall_o), 32'd0);
    chk("reset mask", busy_mask_o, 32'd0);

    wb_reg_we_i = 1; wb_wR_i = 5'd5; wb_wD_i = 32'hDEADBEEF;
    cycle();
    wb_reg_we_i = 0;
    chk("pipe rf_we", 32'(rf_we_o), 32'd1);
    chk("pipe rf_wR", 32'(rf_wR_o), 32'd5);
    chk("pipe rf_wD", rf_wD_o, 32'hDEADBEEF);

    mdu_valid_i = 1; mdu_wR_i = 5'd7; mdu_wD_i = 32'h12345678;
    cycle();
    mdu_valid_i = 0;
    chk("mdu mask N+1", busy_mask_o, 32'h80);
    cycle();
    chk("mdu rf_we", 32'(rf_we_o), 32'd1);
    chk("mdu rf_wR", 32'(rf_wR_o), 32'd7);
    chk("mdu rf_wD", rf_wD_o, 32'h12345678);
    chk("mdu mask N+2", busy_mask_o, 32'd0);

    // starvation: x3 written every cycle while one MDU result waits
    seq = 100;
    wb_reg_we_i = 1; wb_wR_i = 5'd3; wb_wD_i = seq;
    mdu_valid_i = 1; mdu_wR_i = 5'd9; mdu_wD_i = 32'hAAAA5555;
    cycle();
    mdu_valid_i = 0;
    stall_cnt = 0; stall_k = 0; drained = 0;
    for (int k = 1; k <= 8; k++) begin
      if (pipe_stall_o) begin stall_cnt++; stall_k = k; end
      if (rf_we_o && rf_wR_o == 5'd9) drained++;
      if (!last_stall) begin seq++; wb_wD_i = seq; end
      cycle();
    end
    chk("starve stall count", stall_cnt, 32'd1);
    chk("starve stall cycle", stall_k, 32'd5);
    chk("starve drained", drained, 32'd1);
    wb_reg_we_i = 0;
    cycle(); cycle();

    // full buffer with the pipeline busy
    wb_reg_we_i = 1; wb_wR_i = 5'd4; wb_wD_i = 32'h44;
    mdu_valid_i = 1; mdu_wR_i = 5'd10; mdu_wD_i = 32'hA0;
    cycle();
    mdu_wR_i = 5'd11; mdu_wD_i = 32'hB0;
    cycle();
    chk("full ready", 32'(mdu_ready_o), 32'd0);
    chk("full mask", busy_mask_o, 32'h0000_0C00);
    mdu_wR_i = 5'd12; mdu_wD_i = 32'hC0;
    acc_k = -1;
    for (int k = 0; k < 12; k++) begin
      if (k == 2) wb_reg_we_i = 0;
      if (rf_we_o && rf_wR_o >= 5'd10 && rf_wR_o <= 5'd12) ord.push_back(int'(rf_wR_o));
      cycle();
      if (mdu_valid_i && last_acc) begin mdu_valid_i = 0; acc_k = k; end
    end
    chk("full accept cycle", acc_k, 32'd3);
    chk("full write count", ord.size(), 32'd3);
    if (ord.size() == 3) begin
      chk("full order 0", ord[0], 32'd10);
      chk("full order 1", ord[1], 32'd11);
      chk("full order 2", ord[2], 32'd12);
    end

    // x0 filtering
    wb_reg_we_i = 1; wb_wR_i = 5'd0; wb_wD_i = 32'h0BAD0BAD;
    cycle();
    wb_reg_we_i = 0;
    chk("x0 wb rf_we", 32'(rf_we_o), 32'd0);
    chk("x0 mdu ready", 32'(mdu_ready_o), 32'd1);
    mdu_valid_i = 1; mdu_wR_i = 5'd0; mdu_wD_i = 32'h0BADF00D;
    cycle();
    mdu_valid_i = 0;
    chk("x0 mdu mask", busy_mask_o, 32'd0);
    cycle();
    chk("x0 mdu rf_we", 32'(rf_we_o), 32'd0);

    // randomized traffic with upstream hold on stall and MDU hold until accepted
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (!last_stall) begin
        if ((c / 500) % 2 == 0) wb_reg_we_i = ($urandom_range(0, 3) != 0);
        else                    wb_reg_we_i = ($urandom_range(0, 3) == 0);
        wb_wR_i = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        wb_wD_i = $urandom;
      end
      if (!mdu_valid_i || last_acc) begin
        mdu_valid_i = ($urandom_range(0, 2) == 0);
        mdu_wR_i = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        mdu_wD_i = $urandom;
      end
      cycle();
    end
    rst = 0; wb_reg_we_i = 0; mdu_valid_i = 0;
    cycle(); cycle(); cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Arbitrates the single register-file write port between the in-order pipeline writeback (MEM/WB outputs) and a long-latency multiply/divide unit (MDU) that returns results out of band.
- MDU results are buffered in a small FIFO and drained when the pipeline writeback slot is idle.
- An anti-starvation counter forces a one-cycle pipeline stall to drain the buffer.
- Exports a pending-write mask to the hazard unit.
- Sits between the MEM/WB register, the MDU and the register file.

Parameters:
- FIFO_DEPTH, 2, MDU result buffer entries; power of two, at least 2.
- STARVE_LIMIT, 4, blocked-cycle count at which a stall is forced; range 1..15.
- DW, 32, data width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- wb_reg_we_i  input  1  pipeline writeback enable.
- wb_wR_i  input  5  pipeline destination register.
- wb_wD_i  input  DW  pipeline writeback data.
- mdu_valid_i  input  1  MDU result valid.
- mdu_wR_i  input  5  MDU destination register.
- mdu_wD_i  input  DW  MDU result data.
- mdu_ready_o  output  1  buffer can accept an MDU result.
- pipe_stall_o  output  1  freeze the pipeline for this cycle.
- busy_mask_o  output  32  bit r set while a buffered write to xr is pending.
- rf_we_o  output  1  register-file write enable (registered).
- rf_wR_o  output  5  register-file write address (registered).
- rf_wD_o  output  DW  register-file write data (registered).

Behaviour:
- Reset (rst=1 at a clk edge):
  - FIFO emptied; age counter = 0.
  - rf_we_o=0, rf_wR_o=0, rf_wD_o=0.
  - With registered state cleared, the combinational outputs become: mdu_ready_o=1, pipe_stall_o=0, busy_mask_o=0.
  - Reset mid-operation discards all buffered results; the MDU is reset by the same signal.
- Enqueue:
  - Occurs when mdu_valid_i && mdu_ready_o && mdu_wR_i!=0.
  - A valid result with mdu_wR_i==0 is accepted (handshake completes) and discarded.
- mdu_ready_o = (count < FIFO_DEPTH), decoded from registered count only.
  - No same-cycle pass-through when full, even if a drain occurs that cycle.
- Stall:
  - pipe_stall_o = head_valid && age >= STARVE_LIMIT.
  - Combinational from registers, so it never depends on inputs.
- Port selection, evaluated each cycle in priority order:
  1. pipe_stall_o=1: drain the FIFO head. wb_* inputs are ignored; the upstream pipeline holds them and re-presents them next cycle.
  2. wb_reg_we_i=1 and wb_wR_i!=0: the pipeline write wins. If the head is valid, age increments, saturating at 15.
  3. Otherwise, if the head is valid: drain the head.
  4. Otherwise: no write.
- Drain: pop the head, set age to 0, and present the head entry on the rf_* outputs.
- Writes with wb_wR_i==0 never reach the port (rf_we_o=0) and count as an idle slot.
- Latency:
  - Pipeline write at cycle N appears on rf_* at N+1.
  - An MDU result enqueued at N is drained at N+1 at the earliest and appears on rf_* at N+2.
- Simultaneous enqueue and drain in the same cycle: count unchanged, pointers both advance.
- Wrap-around: read/write pointers are log2(FIFO_DEPTH) bits and wrap naturally; count is log2(FIFO_DEPTH)+1 bits.
- busy_mask_o is the OR over valid entries of one-hot(wR).
  - It is combinational from registered FIFO state.
  - A bit stays set while any valid entry targets that register.
- WAW ordering is not checked here. The hazard unit must stall any instruction whose rd or rs hits busy_mask_o.

Optional Feature:
- Macro: WB_ARB_PERF_EN.
- When defined, adds output ports:
  - perf_stall_cnt_o, 16 bits: number of forced-stall cycles.
  - perf_mdu_wr_cnt_o, 16 bits: number of MDU drains.
- Both counters reset to 0 and saturate at 16'hFFFF.
- When undefined, these ports and counters do not exist and the block behaves identically otherwise.

Test Plan:
- Reset then idle:
  - Drive rst=1 for 2 cycles, all inputs 0.
  - Expect rf_we_o=0, mdu_ready_o=1, pipe_stall_o=0, busy_mask_o=0.
- Pipeline-only write:
  - At cycle N: wb_reg_we_i=1, wb_wR_i=5, wb_wD_i=32'hDEADBEEF.
  - At N+1: rf_we_o=1, rf_wR_o=5, rf_wD_o=32'hDEADBEEF.
- MDU drain in an idle slot:
  - At N: mdu_valid_i=1, mdu_wR_i=7, mdu_wD_i=32'h12345678, with wb idle.
  - At N+1: busy_mask_o=32'h80.
  - At N+2: rf_we_o=1, rf_wR_o=7, rf_wD_o=32'h12345678, and busy_mask_o=0.
- Starvation:
  - Enqueue one MDU result, then drive wb_reg_we_i=1 to x3 every cycle.
  - After 4 blocked cycles, pipe_stall_o=1 for exactly 1 cycle and the MDU entry is drained.
  - The wb write presented in the stall cycle is not written; it is written when re-presented the following cycle.
- Full buffer:
  - With wb busy, enqueue 2 results; mdu_ready_o=0 the next cycle.
  - A third mdu_valid_i is held and not accepted until a drain.
  - No result is lost or duplicated; rf writes occur in enqueue order.
- x0 filtering:
  - wb_wR_i=0 with we=1 gives rf_we_o=0 at N+1.
  - mdu_wR_i=0 completes the handshake with busy_mask_o unchanged and no rf write.
